// File: rtl/hpi_txn_ctrl.sv
// hpi_txn_ctrl: turns single-word host requests into timed HPI bus cycles
// for the CY7C67200 (EZ-OTG). Mem ops run an ADDRESS phase (port 2) and
// then a DATA phase (port 0). Mailbox writes use port 1 and status reads
// use port 3, each as a single phase. The ADDRESS phase is dropped when the
// chip's auto-increment pointer already holds the requested address.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a request; req_ready high
// S_SETUP  | cs low, address/data driven, strobes high (1 cycle)
// S_STROBE | hpi_w or hpi_r low for STROBE_CYC cycles
// S_HOLD   | strobes high, cs/address/data held (1 cycle)
// S_RECOV  | cs high; write or read recovery time
// S_DONE   | rsp_valid pulse, then back to IDLE
module hpi_txn_ctrl #(
  parameter int STROBE_CYC   = 2,
  parameter int RECOVERY_CYC = 1,
  parameter int READ_LAT     = 2,
  parameter bit ADDR_SKIP_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOV, S_DONE
  } state_t;

  // Reads must stay in recovery until the I/O pipeline has delivered data.
  localparam int RD_RECOV = (RECOVERY_CYC > READ_LAT - 1) ? RECOVERY_CYC : READ_LAT - 1;
  localparam logic [7:0] STB_LOAD    = 8'(STROBE_CYC - 1);
  localparam logic [7:0] WR_REC_LOAD = 8'(RECOVERY_CYC - 1);
  localparam logic [7:0] RD_REC_LOAD = 8'(RD_RECOV - 1);
  localparam logic [7:0] LAT_LOAD    = 8'(READ_LAT - 1);
  localparam logic PH_ADDR = 1'b0;
  localparam logic PH_DATA = 1'b1;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] phys_q, phys_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  lat_cnt_q, lat_cnt_d;
  logic        lat_run_q, lat_run_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] next_addr_q, next_addr_d;
  logic        addr_valid_q, addr_valid_d;

  logic [15:0] req_phys;
  logic        skip_addr;
  logic        rd_phase_q, rd_phase_d;
  logic        active_d;
  logic [1:0]  port_d;
  logic [15:0] dout_d;
  logic        addr_lsb_unused;

  // The HPI address is word aligned; the byte-select bit is dropped.
  assign req_phys        = {req_addr[15:1], 1'b0};
  assign addr_lsb_unused = req_addr[0];
  assign skip_addr       = ADDR_SKIP_EN && addr_valid_q && (req_phys == next_addr_q);

  assign rd_phase_q = (phase_q == PH_DATA) && op_q[0];
  assign rd_phase_d = (phase_d == PH_DATA) && op_d[0];

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;

  // State and context registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= PH_ADDR;
      op_q         <= '0;
      phys_q       <= '0;
      wdata_q      <= '0;
      lat_cnt_q    <= '0;
      lat_run_q    <= 1'b0;
      cap_q        <= '0;
      next_addr_q  <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      op_q         <= op_d;
      phys_q       <= phys_d;
      wdata_q      <= wdata_d;
      lat_cnt_q    <= lat_cnt_d;
      lat_run_q    <= lat_run_d;
      cap_q        <= cap_d;
      next_addr_q  <= next_addr_d;
      addr_valid_q <= addr_valid_d;
    end
  end

  // Next-state logic: phase sequencing, timers, read capture, pointer tracking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    op_d         = op_q;
    phys_d       = phys_q;
    wdata_d      = wdata_q;
    lat_cnt_d    = lat_cnt_q;
    lat_run_d    = lat_run_q;
    cap_d        = cap_q;
    next_addr_d  = next_addr_q;
    addr_valid_d = addr_valid_q;

    // Read latency timer runs from the last strobe cycle, independent of state.
    if (lat_run_q) begin
      if (lat_cnt_q == '0) begin
        cap_d     = hpi_data_in;
        lat_run_d = 1'b0;
      end else begin
        lat_cnt_d = lat_cnt_q - 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          phys_d  = req_phys;
          wdata_d = req_wdata;
          phase_d = (!req_op[1] && !skip_addr) ? PH_ADDR : PH_DATA;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = STB_LOAD;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          if (rd_phase_q) begin
            lat_run_d = 1'b1;
            lat_cnt_d = LAT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        state_d = S_RECOV;
        cnt_d   = rd_phase_q ? RD_REC_LOAD : WR_REC_LOAD;
      end
      S_RECOV: begin
        if (cnt_q == '0) begin
          if (phase_q == PH_ADDR) begin
            phase_d = PH_DATA;
            state_d = S_SETUP;
          end else begin
            state_d = S_DONE;
            if (!op_q[1]) begin
              next_addr_d  = phys_q + 16'd2;
              addr_valid_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus port and data for the phase being entered.
  always_comb begin
    active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    if (phase_d == PH_ADDR) begin
      port_d = 2'd2;
      dout_d = phys_d;
    end else begin
      port_d = op_d[1] ? (op_d[0] ? 2'd3 : 2'd1) : 2'd0;
      dout_d = wdata_d;
    end
  end

  // Registered bus and response outputs so strobes are glitch free.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hpi_r        <= 1'b1;
      hpi_w        <= 1'b1;
      hpi_cs       <= 1'b1;
      hpi_address  <= '0;
      hpi_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      hpi_cs    <= ~active_d;
      hpi_w     <= ~((state_d == S_STROBE) && !rd_phase_d);
      hpi_r     <= ~((state_d == S_STROBE) && rd_phase_d);
      rsp_valid <= (state_d == S_DONE);
      if (state_d == S_SETUP) begin
        hpi_address  <= port_d;
        hpi_data_out <= dout_d;
      end
      if ((state_d == S_DONE) && op_d[0]) begin
        rsp_rdata <= cap_d;
      end
    end
  end

endmodule

// File: tb/tb_hpi_txn_ctrl.sv
// Directed bench for hpi_txn_ctrl: three instances (default, address skip
// disabled, stretched timing) share stimulus through a select mux.
module tb_hpi_txn_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] hpi_data_in = 16'hDEAD;
  int          sel = 0;

  logic [2:0]  rdy_v, rspv_v, busy_v, r_v, w_v, cs_v;
  logic [15:0] rdata_v [3];
  logic [15:0] dout_v [3];
  logic [1:0]  port_v [3];

  logic        req_ready, rsp_valid, busy, hpi_r, hpi_w, hpi_cs;
  logic [15:0] rsp_rdata, hpi_data_out;
  logic [1:0]  hpi_address;

  int checks = 0;
  int failures = 0;

  int          t_rsp, t_nw, t_nr, t_nacc, t_cshi, t_viol;
  logic [1:0]  t_port [2];
  logic [15:0] t_data [2];

  always #5 Clk = ~Clk;

  assign req_ready    = rdy_v[sel];
  assign rsp_valid    = rspv_v[sel];
  assign busy         = busy_v[sel];
  assign hpi_r        = r_v[sel];
  assign hpi_w        = w_v[sel];
  assign hpi_cs       = cs_v[sel];
  assign rsp_rdata    = rdata_v[sel];
  assign hpi_data_out = dout_v[sel];
  assign hpi_address  = port_v[sel];

  hpi_txn_ctrl u_dflt (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid && sel == 0), .req_ready(rdy_v[0]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv_v[0]), .rsp_rdata(rdata_v[0]), .busy(busy_v[0]),
    .hpi_address(port_v[0]), .hpi_data_out(dout_v[0]), .hpi_data_in(hpi_data_in),
    .hpi_r(r_v[0]), .hpi_w(w_v[0]), .hpi_cs(cs_v[0]));

  hpi_txn_ctrl #(.ADDR_SKIP_EN(1'b0)) u_noskip (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid && sel == 1), .req_ready(rdy_v[1]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv_v[1]), .rsp_rdata(rdata_v[1]), .busy(busy_v[1]),
    .hpi_address(port_v[1]), .hpi_data_out(dout_v[1]), .hpi_data_in(hpi_data_in),
    .hpi_r(r_v[1]), .hpi_w(w_v[1]), .hpi_cs(cs_v[1]));

  hpi_txn_ctrl #(.STROBE_CYC(4), .RECOVERY_CYC(3), .READ_LAT(5)) u_slow (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid && sel == 2), .req_ready(rdy_v[2]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv_v[2]), .rsp_rdata(rdata_v[2]), .busy(busy_v[2]),
    .hpi_address(port_v[2]), .hpi_data_out(dout_v[2]), .hpi_data_in(hpi_data_in),
    .hpi_r(r_v[2]), .hpi_w(w_v[2]), .hpi_cs(cs_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request (acceptance edge ends cycle 0) and log the bus activity.
  // hpi_data_in carries rval only in cycle cap_cyc, garbage otherwise.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rval, input int cap_cyc);
    bit prev_stb, stb, started;
    t_rsp = -1; t_nw = 0; t_nr = 0; t_nacc = 0; t_cshi = 0; t_viol = 0;
    t_port[0] = 'x; t_port[1] = 'x; t_data[0] = 'x; t_data[1] = 'x;
    @(negedge Clk);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    hpi_data_in = 16'hDEAD;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge Clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    prev_stb = 1'b0;
    started  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      req_valid = 1'b0;
      stb = !hpi_r || !hpi_w;
      if (!hpi_w) t_nw++;
      if (!hpi_r) t_nr++;
      if (!hpi_r && !hpi_w) t_viol++;
      if (stb && hpi_cs) t_viol++;
      if (stb && !prev_stb) begin
        if (t_nacc < 2) begin
          t_port[t_nacc] = hpi_address;
          t_data[t_nacc] = hpi_data_out;
        end
        t_nacc++;
      end
      if (!hpi_cs) started = 1'b1;
      else if (started && !rsp_valid) t_cshi++;
      prev_stb = stb;
      hpi_data_in = (k == cap_cyc) ? rval : 16'hDEAD;
      if (rsp_valid) begin
        t_rsp = k;
        break;
      end
    end
    chk({tag, "_proto"}, 32'(t_viol), 32'd0);
    @(negedge Clk);
    chk({tag, "_pulse"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int rsp_seen;

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_strobes", {29'd0, hpi_r, hpi_w, hpi_cs}, 32'h7);
    chk("rst_ready",   {30'd0, req_ready, busy}, 32'h2);
    chk("rst_rsp",     {15'd0, rsp_valid, rsp_rdata}, 32'h0);
    chk("rst_bus",     {14'd0, hpi_address, hpi_data_out}, 32'h0);

    // Two-phase mem write.
    run_txn("wr1000", 2'b00, 16'h1000, 16'hBEEF, 16'h0, 0);
    chk("wr1000_rsp",  t_rsp, 11);
    chk("wr1000_nacc", t_nacc, 2);
    chk("wr1000_a0",   {14'd0, t_port[0], t_data[0]}, 32'h0002_1000);
    chk("wr1000_a1",   {14'd0, t_port[1], t_data[1]}, 32'h0000_BEEF);
    chk("wr1000_stb",  {t_nw[15:0], t_nr[15:0]}, 32'h0004_0000);
    chk("wr1000_cshi", t_cshi, 2);
    chk("wr1000_rd",   rsp_rdata, 16'h0000);

    // Sequential read: address phase skipped.
    run_txn("rd1002", 2'b01, 16'h1002, 16'h0, 16'h1234, 5);
    chk("rd1002_rsp",  t_rsp, 6);
    chk("rd1002_nacc", t_nacc, 1);
    chk("rd1002_port", t_port[0], 2'd0);
    chk("rd1002_stb",  {t_nw[15:0], t_nr[15:0]}, 32'h0000_0002);
    chk("rd1002_rd",   rsp_rdata, 16'h1234);

    // Wrap of the auto-increment pointer.
    run_txn("wrfffe", 2'b00, 16'hFFFE, 16'h5555, 16'h0, 0);
    chk("wrfffe_rsp", t_rsp, 11);
    chk("wrfffe_a0",  {14'd0, t_port[0], t_data[0]}, 32'h0002_FFFE);
    run_txn("rd0000", 2'b01, 16'h0000, 16'h0, 16'hA5A5, 5);
    chk("rd0000_rsp",  t_rsp, 6);
    chk("rd0000_nacc", t_nacc, 1);
    chk("rd0000_rd",   rsp_rdata, 16'hA5A5);
    run_txn("rd0003", 2'b01, 16'h0003, 16'h0, 16'h0F0F, 5);
    chk("rd0003_rsp",  t_rsp, 6);
    chk("rd0003_nacc", t_nacc, 1);
    chk("rd0003_rd",   rsp_rdata, 16'h0F0F);

    // Mailbox write, status read, then mem op to the tracked pointer.
    run_txn("mbx", 2'b10, 16'h0040, 16'hCE01, 16'h0, 0);
    chk("mbx_rsp", t_rsp, 6);
    chk("mbx_a0",  {14'd0, t_port[0], t_data[0]}, 32'h0001_CE01);
    chk("mbx_stb", {t_nw[15:0], t_nr[15:0]}, 32'h0002_0000);
    chk("mbx_rd",  rsp_rdata, 16'h0F0F);
    run_txn("sts", 2'b11, 16'h0080, 16'h0, 16'h0001, 5);
    chk("sts_rsp",  t_rsp, 6);
    chk("sts_port", t_port[0], 2'd3);
    chk("sts_stb",  {t_nw[15:0], t_nr[15:0]}, 32'h0000_0002);
    chk("sts_rd",   rsp_rdata, 16'h0001);
    run_txn("wr0004", 2'b00, 16'h0004, 16'h7777, 16'h0, 0);
    chk("wr0004_rsp",  t_rsp, 6);
    chk("wr0004_nacc", t_nacc, 1);
    chk("wr0004_a0",   {14'd0, t_port[0], t_data[0]}, 32'h0000_7777);

    // Reset during the DATA strobe of a two-phase mem read.
    @(negedge Clk);
    req_op = 2'b01; req_addr = 16'h2000; req_valid = 1'b1;
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clk);
      req_valid = 1'b0;
    end
    chk("rstmid_pre", {31'd0, hpi_r}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rstmid_strobes", {29'd0, hpi_r, hpi_w, hpi_cs}, 32'h7);
    chk("rstmid_ready",   {30'd0, req_ready, rsp_valid}, 32'h2);
    Reset = 1'b0;
    rsp_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (rsp_valid) rsp_seen++;
    end
    chk("rstmid_norsp", rsp_seen, 0);
    run_txn("rd0006", 2'b01, 16'h0006, 16'h0, 16'h4321, 10);
    chk("rd0006_rsp",  t_rsp, 11);
    chk("rd0006_nacc", t_nacc, 2);
    chk("rd0006_a0",   {14'd0, t_port[0], t_data[0]}, 32'h0002_0006);
    chk("rd0006_rd",   rsp_rdata, 16'h4321);

    // Address skip disabled: sequential read still does both phases.
    sel = 1;
    run_txn("ns_wr", 2'b00, 16'h1000, 16'hBEEF, 16'h0, 0);
    chk("ns_wr_rsp", t_rsp, 11);
    run_txn("ns_rd", 2'b01, 16'h1002, 16'h0, 16'h1234, 10);
    chk("ns_rd_rsp",  t_rsp, 11);
    chk("ns_rd_nacc", t_nacc, 2);
    chk("ns_rd_a0",   {14'd0, t_port[0], t_data[0]}, 32'h0002_1002);
    chk("ns_rd_rd",   rsp_rdata, 16'h1234);

    // Stretched timing: strobe 4, recovery max(3, 5-1)=4, capture at cycle 5+5.
    sel = 2;
    run_txn("slow", 2'b11, 16'h0000, 16'h0, 16'h00C3, 10);
    chk("slow_rsp",  t_rsp, 11);
    chk("slow_stb",  {t_nw[15:0], t_nr[15:0]}, 32'h0000_0004);
    chk("slow_cshi", t_cshi, 4);
    chk("slow_rd",   rsp_rdata, 16'h00C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpi_txn_ctrl.md
Name: hpi_txn_ctrl

Overview:
Hardware sequencer for the CY7C67200 (EZ-OTG) HPI port. It turns single-word requests into correctly timed HPI bus cycles, so the host no longer bit-bangs address, strobe and chip-select. Its bus-side outputs use the same active-low r/w/cs convention as the from_sw_* inputs of hpi_io_intf and connect directly to them. Supported requests are CY memory write/read (ADDRESS phase, then DATA phase), mailbox write and status read.

Parameters:
STROBE_CYC, 2, cycles hpi_r/hpi_w held low per access (>=1)
RECOVERY_CYC, 1, cycles hpi_cs held high between accesses (>=1)
READ_LAT, 2, cycles from last strobe-low cycle to valid hpi_data_in (the I/O interface register pipeline)
ADDR_SKIP_EN, 1, 1 = omit the ADDRESS phase when the HPI auto-increment already points at req_addr

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
req_op  in  2  00 mem write, 01 mem read, 10 mailbox write, 11 status read
req_addr  in  16  CY memory byte address; bit0 ignored and sent as 0
req_wdata  in  16  write data (mem write, mailbox)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  16  read result; updated only by read ops, held otherwise
busy  out  1  ~req_ready
hpi_address  out  2  HPI port select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
hpi_data_out  out  16  write data to the I/O interface
hpi_data_in  in  16  registered read data from the I/O interface
hpi_r, hpi_w, hpi_cs  out  1 each  active-low strobes

Behaviour:
- Reset values: hpi_r=hpi_w=hpi_cs=1, hpi_address=0, hpi_data_out=0, rsp_valid=0, rsp_rdata=0. Internal addr_valid=0. State=IDLE, so req_ready=1 on the first cycle after reset.
- Inputs are sampled at acceptance. req_op, req_addr and req_wdata are don't-care after that point.
- States: IDLE, SETUP, STROBE, HOLD, RECOV, DONE. A phase counter selects ADDRESS or DATA phase.
- One phase, cycle by cycle:
  - SETUP (1 cycle): cs=0, address and data_out driven, strobes high.
  - STROBE (STROBE_CYC cycles): hpi_w=0 for writes or hpi_r=0 for reads.
  - HOLD (1 cycle): strobes high, cs=0, address and data still held.
  - RECOV: cs=1. Lasts RECOVERY_CYC cycles for writes and max(RECOVERY_CYC, READ_LAT-1) cycles for reads.
- Read capture: hpi_data_in is latched on the cycle READ_LAT after the last STROBE cycle.
- Mem ops: ADDRESS phase (port 2, write {req_addr[15:1],1'b0}), then DATA phase (port 0, write req_wdata or read).
- Mailbox write: a single phase on port 1. Status read: a single phase on port 3.
- DONE (1 cycle): rsp_valid=1, rsp_rdata=captured value for reads. The next state is IDLE.
- Auto-increment tracking:
  - After every mem DATA phase: next_addr = phys_addr+2, mod 2^16, so 0xFFFE wraps to 0x0000. addr_valid=1.
  - If ADDR_SKIP_EN=1, addr_valid=1 and {req_addr[15:1],0}==next_addr, the ADDRESS phase is skipped.
  - Mailbox and status ops leave next_addr and addr_valid unchanged.
- Default latency (acceptance in cycle 0):
  - mem write/read, two phases: rsp_valid in cycle 11; req_ready high again in cycle 12.
  - Single-phase op, or skipped-address mem op: rsp_valid in cycle 6.
- Back-to-back requests: a request held on req_valid during DONE is not accepted until IDLE. There is no overlap, and cs is always high for ≥RECOVERY_CYC cycles between accesses.
- Reset mid-operation: the transaction is abandoned. Strobes and cs go high on the cycle after the reset edge. No rsp_valid is issued and addr_valid is cleared.
- At most one strobe is low at any time. hpi_r and hpi_w are never low while hpi_cs=1.

Test Plan:
- Mem write 0x1000←0xBEEF, defaults -> port2 write of 0x1000 then port0 write of 0xBEEF. Each hpi_w low exactly 2 cycles. rsp_valid in cycle 11, rsp_rdata unchanged.
- Mem read 0x1002 immediately after, bench returns 0x1234 on hpi_data_in -> ADDRESS phase skipped (port0 only). rsp_valid in cycle 6 with rsp_rdata=0x1234. Repeat with ADDR_SKIP_EN=0 -> both phases, rsp in cycle 11.
- Mem write 0xFFFE, then mem read 0x0000 -> address wrap; skip taken. Mem read 0x0003 after a 0x0000 access -> treated as 0x0002 and skipped.
- Mailbox write 0xCE01, then status read returning 0x0001 -> port1 write, then port3 read. rsp_rdata=0x0001. A following mem op to next_addr still skips.
- Assert Reset during STROBE of a mem read -> next cycle hpi_r=hpi_w=hpi_cs=1, no rsp_valid, req_ready=1. The next mem op performs the ADDRESS phase.
- STROBE_CYC=4, RECOVERY_CYC=3, READ_LAT=5 status read -> hpi_r low 4 cycles, cs high 4 cycles after HOLD, capture on cycle last_strobe+5, rsp_valid in cycle 11.
